// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port 32-word data memory between the CPU (R0)
// and the debug/DMA port (R1); one access per IDLE -> ACCESS -> DONE pass.
module dmem_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic          R0Req,
    input  logic          R1Req,
    input  logic          R0We,
    input  logic          R1We,
    input  logic [AW-1:0] R0Addr,
    input  logic [AW-1:0] R1Addr,
    input  logic [DW-1:0] R0Din,
    input  logic [DW-1:0] R1Din,
    output logic          R0Ack,
    output logic          R1Ack,
    output logic [DW-1:0] R0Dout,
    output logic [DW-1:0] R1Dout,
    output logic [1:0]    Gnt,
    output logic [AW-1:0] MAddr,
    output logic [DW-1:0] MDin,
    output logic          MWe,
    input  logic [DW-1:0] MDout
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

    logic [1:0] state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;
    logic       access;
    logic       sel_we;

    assign access = (state_q == StAccess);
    assign sel_we = sel_q ? R1We : R0We;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (R0Req || R1Req) begin
                    // On contention the requester not served last wins.
                    sel_d   = (R0Req && R1Req) ? ~last_q : R1Req;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                last_d  = sel_q;
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Memory drive is live only during ACCESS; everywhere else it idles at zero.
    always_comb begin
        Gnt   = 2'b00;
        MAddr = '0;
        MDin  = '0;
        MWe   = 1'b0;
        if (access) begin
            Gnt   = sel_q ? 2'b10 : 2'b01;
            MAddr = sel_q ? R1Addr : R0Addr;
            MDin  = sel_q ? R1Din : R0Din;
            MWe   = sel_we;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            R0Ack   <= 1'b0;
            R1Ack   <= 1'b0;
            R0Dout  <= '0;
            R1Dout  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            // Ack rises at the end of ACCESS and falls at the end of DONE.
            R0Ack   <= access && !sel_q;
            R1Ack   <= access && sel_q;
            if (access && !sel_q && !sel_we) begin
                R0Dout <= MDout;
            end
            if (access && sel_q && !sel_we) begin
                R1Dout <= MDout;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-scheduling reference model and a 32-word memory model.
module tb_dmem_arbiter;

    logic        Clk = 1'b0;
    logic        Clrn;
    logic        R0Req, R1Req, R0We, R1We;
    logic [31:0] R0Addr, R1Addr, R0Din, R1Din;
    logic        R0Ack, R1Ack;
    logic [31:0] R0Dout, R1Dout;
    logic [1:0]  Gnt;
    logic [31:0] MAddr, MDin, MDout;
    logic        MWe;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    dmem_arbiter #(.DW(32), .AW(32)) dut (
        .Clk(Clk), .Clrn(Clrn),
        .R0Req(R0Req), .R1Req(R1Req), .R0We(R0We), .R1We(R1We),
        .R0Addr(R0Addr), .R1Addr(R1Addr), .R0Din(R0Din), .R1Din(R1Din),
        .R0Ack(R0Ack), .R1Ack(R1Ack), .R0Dout(R0Dout), .R1Dout(R1Dout),
        .Gnt(Gnt), .MAddr(MAddr), .MDin(MDin), .MWe(MWe), .MDout(MDout)
    );

    // Memory: combinational read, posedge write, word i preloaded with i.
    logic [31:0] mem [32];
    bit          loaded = 1'b0;
    always @(posedge Clk) begin
        if (!loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
            loaded <= 1'b1;
        end else if (MWe) begin
            mem[MAddr[6:2]] <= MDin;
        end
    end
    assign MDout = mem[MAddr[6:2]];

    // Reference model: each grant decided in a free cycle c occupies cycles c+1 (grant)
    // and c+2 (ack); the arbiter is free again at c+3.
    int          cyc     = 0;
    int          gnt_at  = -10;
    int          ack_at  = -10;
    int          free_at = 0;
    bit          who     = 1'b0;
    bit          last    = 1'b1;
    logic [31:0] ref_mem [32];
    logic [31:0] exp_dout0 = '0, exp_dout1 = '0;
    logic [31:0] cur_addr, cur_din;
    logic        cur_we;
    logic [1:0]  exp_gnt;
    logic        exp_we, exp_ack0, exp_ack1;
    logic [31:0] exp_addr, exp_din;

    assign cur_addr = who ? R1Addr : R0Addr;
    assign cur_din  = who ? R1Din : R0Din;
    assign cur_we   = who ? R1We : R0We;

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 32; i++) ref_mem[i] <= 32'(i);
        end
        if (!Clrn) begin
            if (cyc == gnt_at && cur_we) ref_mem[cur_addr[6:2]] <= cur_din;
            last      <= 1'b1;
            exp_dout0 <= '0;
            exp_dout1 <= '0;
            gnt_at    <= -10;
            ack_at    <= -10;
            free_at   <= cyc + 1;
        end else begin
            if (cyc == gnt_at) begin
                if (cur_we) ref_mem[cur_addr[6:2]] <= cur_din;
                else if (!who) exp_dout0 <= ref_mem[cur_addr[6:2]];
                else exp_dout1 <= ref_mem[cur_addr[6:2]];
                last <= who;
            end
            if (cyc >= free_at && (R0Req || R1Req)) begin
                who     <= (R0Req && R1Req) ? !last : R1Req;
                gnt_at  <= cyc + 1;
                ack_at  <= cyc + 2;
                free_at <= cyc + 3;
            end
        end
    end

    always_comb begin
        exp_gnt  = 2'b00;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_din  = '0;
        if (cyc == gnt_at) begin
            exp_gnt  = who ? 2'b10 : 2'b01;
            exp_we   = cur_we;
            exp_addr = cur_addr;
            exp_din  = cur_din;
        end
        exp_ack0 = (cyc == ack_at) && !who;
        exp_ack1 = (cyc == ack_at) && who;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic sample();
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Clrn = 1'b0;
        R0Req = 1'b1; R0We = 1'b0; R0Addr = 32'h0C; R0Din = '0;
        R1Req = 1'b1; R1We = 1'b0; R1Addr = 32'h1C; R1Din = '0;
        for (int k = 0; k < 2; k++) begin
            tick();
            sample();
            n_tests++;
            if ({R0Ack, R1Ack, Gnt, MWe} !== 5'b0 || R0Dout !== 0 || R1Dout !== 0) begin
                n_fail++;
                $display("FAIL reset_state: ack=%b%b gnt=%b mwe=%b d0=%h d1=%h, want all zero",
                         R0Ack, R1Ack, Gnt, MWe, R0Dout, R1Dout);
            end
        end
        tick();
        Clrn = 1'b1;
        tick();
        sample();
        n_tests++;
        if (Gnt !== 2'b01 || MAddr !== 32'h0C) begin
            n_fail++;
            $display("FAIL reset_first_grant: gnt=%b addr=%h, want 01 0000000c", Gnt, MAddr);
        end
        tick();
        sample();
        n_tests++;
        if (R0Ack !== 1'b1 || R1Ack !== 1'b0 || R0Dout !== 32'd3) begin
            n_fail++;
            $display("FAIL reset_first_ack: ack=%b%b d0=%h, want 10 00000003", R0Ack, R1Ack, R0Dout);
        end
        tick();
        R0Req = 1'b0;
        tick();
        sample();
        n_tests++;
        if (Gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_second_grant: gnt=%b, want 10", Gnt);
        end
        tick();
        sample();
        n_tests++;
        if (R1Ack !== 1'b1 || R1Dout !== 32'd7) begin
            n_fail++;
            $display("FAIL reset_second_ack: ack1=%b d1=%h, want 1 00000007", R1Ack, R1Dout);
        end
        tick();
        R1Req = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        R0Req = 1'b1; R0We = 1'b0; R0Addr = 32'h14;
        sample();
        n_tests++;
        if (Gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL read_idle_gnt: gnt=%b, want 00", Gnt);
        end
        tick();
        sample();
        n_tests++;
        if (Gnt !== 2'b01 || MAddr !== 32'h14 || MWe !== 1'b0) begin
            n_fail++;
            $display("FAIL read_access: gnt=%b addr=%h we=%b, want 01 00000014 0", Gnt, MAddr, MWe);
        end
        tick();
        sample();
        n_tests++;
        if (R0Ack !== 1'b1 || R1Ack !== 1'b0 || R0Dout !== 32'd5 || R1Dout !== 32'd7) begin
            n_fail++;
            $display("FAIL read_ack: ack=%b%b d0=%h d1=%h, want 10 00000005 00000007",
                     R0Ack, R1Ack, R0Dout, R1Dout);
        end
        tick();
        R0Req = 1'b0;
        sample();
        n_tests++;
        if (R0Ack !== 1'b0) begin
            n_fail++;
            $display("FAIL read_ack_pulse: ack0=%b, want 0", R0Ack);
        end
        tick();
    endtask

    task automatic test_write_then_read();
        R1Req = 1'b1; R1We = 1'b1; R1Addr = 32'h08; R1Din = 32'hDEADBEEF;
        tick();
        sample();
        n_tests++;
        if (Gnt !== 2'b10 || MWe !== 1'b1 || MAddr !== 32'h08 || MDin !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_access: gnt=%b we=%b addr=%h din=%h, want 10 1 00000008 deadbeef",
                     Gnt, MWe, MAddr, MDin);
        end
        tick();
        sample();
        n_tests++;
        if (R1Ack !== 1'b1 || MWe !== 1'b0 || R1Dout !== 32'd7) begin
            n_fail++;
            $display("FAIL write_ack: ack1=%b we=%b d1=%h, want 1 0 00000007", R1Ack, MWe, R1Dout);
        end
        tick();
        R1Req = 1'b0; R1We = 1'b0;
        R0Req = 1'b1; R0We = 1'b0; R0Addr = 32'h08;
        tick();
        sample();
        n_tests++;
        if (Gnt !== 2'b01 || MWe !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_read_access: gnt=%b we=%b, want 01 0", Gnt, MWe);
        end
        tick();
        sample();
        n_tests++;
        if (R0Ack !== 1'b1 || R0Dout !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_read_data: ack0=%b d0=%h, want 1 deadbeef", R0Ack, R0Dout);
        end
        tick();
        R0Req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic [3:0] want;
        Clrn = 1'b0;
        tick();
        Clrn = 1'b1;
        R0Req = 1'b1; R0We = 1'b0; R0Addr = 32'h14;
        R1Req = 1'b1; R1We = 1'b0; R1Addr = 32'h08;
        for (int k = 0; k < 12; k++) begin
            want = 4'b0;
            if (k % 3 == 1) want[3:2] = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
            if (k % 3 == 2) want[1:0] = ((k / 3) % 2 == 0) ? 2'b10 : 2'b01;
            sample();
            n_tests++;
            if ({Gnt, R0Ack, R1Ack} !== want) begin
                n_fail++;
                $display("FAIL contention k=%0d: gnt,ack0,ack1=%b, want %b",
                         k, {Gnt, R0Ack, R1Ack}, want);
            end
            tick();
        end
        R0Req = 1'b0;
        R1Req = 1'b0;
        sample();
        n_tests++;
        if (R0Dout !== 32'd5 || R1Dout !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL contention_data: d0=%h d1=%h, want 00000005 deadbeef", R0Dout, R1Dout);
        end
        tick();
    endtask

    task automatic test_late_arrival();
        logic [3:0] want;
        R0Req = 1'b1; R0We = 1'b0; R0Addr = 32'h14;
        for (int k = 0; k < 7; k++) begin
            if (k == 1) begin
                R1Req = 1'b1; R1We = 1'b0; R1Addr = 32'h04;
            end
            if (k == 3) R0Req = 1'b0;
            if (k == 6) R1Req = 1'b0;
            case (k)
                1:       want = 4'b0100;
                2:       want = 4'b0010;
                4:       want = 4'b1000;
                5:       want = 4'b0001;
                default: want = 4'b0000;
            endcase
            sample();
            n_tests++;
            if ({Gnt, R0Ack, R1Ack} !== want) begin
                n_fail++;
                $display("FAIL late_arrival k=%0d: gnt,ack0,ack1=%b, want %b",
                         k, {Gnt, R0Ack, R1Ack}, want);
            end
            tick();
        end
        sample();
        n_tests++;
        if (R1Dout !== 32'd1) begin
            n_fail++;
            $display("FAIL late_arrival_data: d1=%h, want 00000001", R1Dout);
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        R0Req = 1'b1; R0We = 1'b1; R0Addr = 32'h10; R0Din = 32'h12345678;
        tick();
        Clrn = 1'b0;
        sample();
        n_tests++;
        if (Gnt !== 2'b01 || MWe !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_access: gnt=%b we=%b, want 01 1", Gnt, MWe);
        end
        tick();
        Clrn = 1'b1;
        R0Req = 1'b0; R0We = 1'b0;
        sample();
        n_tests++;
        if (R0Ack !== 1'b0 || Gnt !== 2'b00 || R0Dout !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_no_ack: ack0=%b gnt=%b d0=%h, want 0 00 00000000",
                     R0Ack, Gnt, R0Dout);
        end
        tick();
        R0Req = 1'b1;
        tick();
        tick();
        sample();
        n_tests++;
        if (R0Ack !== 1'b1 || R0Dout !== 32'h12345678) begin
            n_fail++;
            $display("FAIL midreset_readback: ack0=%b d0=%h, want 1 12345678", R0Ack, R0Dout);
        end
        tick();
        R0Req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit seen0 = 1'b0, seen1 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            Clrn = ($urandom_range(0, 49) != 0);
            if (R0Req && seen0) R0Req = 1'b0;
            if (R1Req && seen1) R1Req = 1'b0;
            if (!R0Req && $urandom_range(0, 2) == 0) begin
                R0Req = 1'b1; R0We = 1'($urandom_range(0, 1));
                R0Addr = $urandom; R0Din = $urandom;
            end
            if (!R1Req && $urandom_range(0, 2) == 0) begin
                R1Req = 1'b1; R1We = 1'($urandom_range(0, 1));
                R1Addr = $urandom; R1Din = $urandom;
            end
            sample();
            n_tests++;
            if ({Gnt, MWe, MAddr, MDin, R0Ack, R1Ack} !==
                {exp_gnt, exp_we, exp_addr, exp_din, exp_ack0, exp_ack1}) begin
                n_fail++;
                $display("FAIL random_bus c=%0d: gnt=%b we=%b addr=%h din=%h ack=%b%b, want %b %b %h %h %b%b",
                         c, Gnt, MWe, MAddr, MDin, R0Ack, R1Ack,
                         exp_gnt, exp_we, exp_addr, exp_din, exp_ack0, exp_ack1);
            end
            n_tests++;
            if (R0Dout !== exp_dout0 || R1Dout !== exp_dout1) begin
                n_fail++;
                $display("FAIL random_dout c=%0d: d0=%h d1=%h, want %h %h",
                         c, R0Dout, R1Dout, exp_dout0, exp_dout1);
            end
            seen0 = R0Ack;
            seen1 = R1Ack;
            tick();
        end
        Clrn  = 1'b1;
        R0Req = 1'b0;
        R1Req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_then_read();
        test_contention();
        test_late_arrival();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
